// File: rtl/fifo2axi_unpack.sv
// fifo2axi_unpack: rebuilds 256-bit AXI4-Stream beats from 192-bit memory words.
// Word layout: {payload[201:10], bcnt[9:5], phase[4:2], last[1], rsvd[0]}.
// Packet layout: one header word carrying tuser, then 4 data words per 3 beats.
// Optional macro FIFO2AXI_PHASE_CHECK_EN: compare each word's phase field with
// the expected state and resynchronise on the next header after a mismatch.
module fifo2axi_unpack #(
  parameter int TDATA_WIDTH        = 32,
  parameter int TSTRB_WIDTH        = TDATA_WIDTH/8,
  parameter int TUSER_WIDTH        = 16,
  parameter int CROPPED_DATA_WIDTH = 24
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [8*CROPPED_DATA_WIDTH+9:0] din,
  input  logic                            din_valid,
  output logic                            din_rd,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic [8*TDATA_WIDTH-1:0]        m_tdata,
  output logic [8*TSTRB_WIDTH-1:0]        m_tstrb,
  output logic [8*TUSER_WIDTH-1:0]        m_tuser,
  output logic                            m_tlast,
  output logic                            proto_err
);

  localparam int DW = 8*TDATA_WIDTH;
  localparam int PW = 8*CROPPED_DATA_WIDTH;
  localparam int UW = 8*TUSER_WIDTH;
  localparam int SW = 8*TSTRB_WIDTH;

`ifdef FIFO2AXI_PHASE_CHECK_EN
  typedef enum logic [2:0] {
    HDR = 3'd0, W1 = 3'd1, W2 = 3'd2, W3 = 3'd3, W4 = 3'd4, RESYNC = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    HDR = 3'd0, W1 = 3'd1, W2 = 3'd2, W3 = 3'd3, W4 = 3'd4
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [UW-1:0] tuser_hold_q, tuser_hold_d;
  logic [PW-1:0] hold_a_q, hold_a_d;
  logic [127:0]  hold_b_q, hold_b_d;
  logic [63:0]   hold_c_q, hold_c_d;
  logic          m_tvalid_q, m_tvalid_d;
  logic [DW-1:0] m_tdata_q, m_tdata_d;
  logic [SW-1:0] m_tstrb_q, m_tstrb_d;
  logic [UW-1:0] m_tuser_q, m_tuser_d;
  logic          m_tlast_q, m_tlast_d;
  logic          proto_err_q, proto_err_d;

  logic [PW-1:0] payload;
  logic [4:0]    bcnt;
  logic [2:0]    phase;
  logic          last;
  logic          pop;
  logic          phase_bad;
  logic          load;
  logic [DW-1:0] beat;
  logic [SW-1:0] last_strb;

  assign payload   = din[PW+9:10];
  assign bcnt      = din[9:5];
  assign phase     = din[4:2];
  assign last      = din[1];
  // bcnt is bytes-1, so a shift by (31 - bcnt) leaves bcnt+1 low ones
  assign last_strb = {SW{1'b1}} >> (5'd31 - bcnt);

`ifdef FIFO2AXI_PHASE_CHECK_EN
  logic unused_rsvd;
  assign unused_rsvd = din[0];
  assign phase_bad   = (state_q != RESYNC) && (phase != 3'(state_q));
`else
  logic unused_bits;
  assign unused_bits = ^{din[0], phase};
  assign phase_bad   = 1'b0;
`endif

  // Pop control: header/first word never need the output slot; beat-completing words do.
  always_comb begin
    din_rd = din_valid;
    if (state_q == W2 || state_q == W3 || state_q == W4)
      din_rd = din_valid & (~m_tvalid_q | m_tready);
  end

  assign pop = din_valid & din_rd;

  // Next-state, holding registers and output register update.
  always_comb begin
    state_d      = state_q;
    tuser_hold_d = tuser_hold_q;
    hold_a_d     = hold_a_q;
    hold_b_d     = hold_b_q;
    hold_c_d     = hold_c_q;
    m_tdata_d    = m_tdata_q;
    m_tstrb_d    = m_tstrb_q;
    m_tuser_d    = m_tuser_q;
    m_tlast_d    = m_tlast_q;
    m_tvalid_d   = m_tvalid_q & ~m_tready;
    proto_err_d  = 1'b0;
    load         = 1'b0;
    beat         = '0;
    if (pop) begin
      if (phase_bad) begin
`ifdef FIFO2AXI_PHASE_CHECK_EN
        proto_err_d = 1'b1;
        state_d     = RESYNC;
`endif
      end else begin
        case (state_q)
          HDR: begin
            tuser_hold_d = payload[UW-1:0];
            state_d      = W1;
          end
          W1: begin
            if (last) begin
              proto_err_d = 1'b1;
              state_d     = HDR;
            end else begin
              hold_a_d = payload;
              state_d  = W2;
            end
          end
          W2: begin
            load     = 1'b1;
            beat     = {payload[63:0], hold_a_q};
            hold_b_d = payload[191:64];
            state_d  = last ? HDR : W3;
          end
          W3: begin
            load     = 1'b1;
            beat     = {payload[127:0], hold_b_q};
            hold_c_d = payload[191:128];
            state_d  = last ? HDR : W4;
          end
          W4: begin
            load    = 1'b1;
            beat    = {payload, hold_c_q};
            state_d = last ? HDR : W1;
          end
`ifdef FIFO2AXI_PHASE_CHECK_EN
          RESYNC: begin
            if (phase == 3'd0) begin
              tuser_hold_d = payload[UW-1:0];
              state_d      = W1;
            end
          end
`endif
          default: state_d = HDR;
        endcase
      end
    end
    if (load) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = beat;
      m_tuser_d  = tuser_hold_q;
      m_tlast_d  = last;
      m_tstrb_d  = last ? last_strb : {SW{1'b1}};
    end
  end

  // State and registered outputs; reset drops any partially built beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= HDR;
      tuser_hold_q <= '0;
      hold_a_q     <= '0;
      hold_b_q     <= '0;
      hold_c_q     <= '0;
      m_tvalid_q   <= 1'b0;
      m_tdata_q    <= '0;
      m_tstrb_q    <= '0;
      m_tuser_q    <= '0;
      m_tlast_q    <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tuser_hold_q <= tuser_hold_d;
      hold_a_q     <= hold_a_d;
      hold_b_q     <= hold_b_d;
      hold_c_q     <= hold_c_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tdata_q    <= m_tdata_d;
      m_tstrb_q    <= m_tstrb_d;
      m_tuser_q    <= m_tuser_d;
      m_tlast_q    <= m_tlast_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign m_tvalid  = m_tvalid_q;
  assign m_tdata   = m_tdata_q;
  assign m_tstrb   = m_tstrb_q;
  assign m_tuser   = m_tuser_q;
  assign m_tlast   = m_tlast_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_fifo2axi_unpack.sv
// Directed bench for fifo2axi_unpack: packet unpacking, strobes, stalls,
// back-to-back packets, mid-packet reset and protocol errors.
module tb_fifo2axi_unpack;

  logic         clk = 1'b0;
  logic         reset;
  logic [201:0] din;
  logic         din_valid;
  logic         din_rd;
  logic         m_tvalid;
  logic         m_tready;
  logic [255:0] m_tdata;
  logic [31:0]  m_tstrb;
  logic [127:0] m_tuser;
  logic         m_tlast;
  logic         proto_err;

  fifo2axi_unpack #(
    .TDATA_WIDTH(32),
    .TUSER_WIDTH(16),
    .CROPPED_DATA_WIDTH(24)
  ) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_rd(din_rd),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tstrb(m_tstrb),
    .m_tuser(m_tuser), .m_tlast(m_tlast), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  strb;
    logic [127:0] user;
    logic         last;
    int           cyc;
  } beat_t;

  logic [201:0] feed_q[$];
  beat_t        got_q[$];
  beat_t        exp_q[$];
  int           cyc = 0;
  int           perr_cnt = 0;
  int           n_chk = 0;
  int           n_pass = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [201:0] mkw(input logic [191:0] pl, input logic [4:0] bcnt,
                                       input logic [2:0] ph, input logic lst);
    return {pl, bcnt, ph, lst, 1'b1};
  endfunction

  // Cycle counter used to time-stamp accepted beats
  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted beat
  always @(negedge clk)
    if (!reset && m_tvalid && m_tready)
      got_q.push_back('{m_tdata, m_tstrb, m_tuser, m_tlast, cyc});

  // Count protocol-error pulses
  always @(negedge clk)
    if (!reset && proto_err) perr_cnt <= perr_cnt + 1;

  // Fall-through FIFO model feeding din
  initial begin
    logic popnow;
    din_valid = 1'b0;
    din       = '0;
    forever begin
      @(negedge clk);
      popnow = din_valid && din_rd && !reset;
      @(posedge clk);
      #1;
      if (popnow && feed_q.size() > 0) void'(feed_q.pop_front());
      if (feed_q.size() > 0 && !reset) begin
        din       = feed_q[0];
        din_valid = 1'b1;
      end else begin
        din_valid = 1'b0;
      end
    end
  end

  // Header plus data words; packet byte n carries value seed+n
  task automatic send_pkt(input logic [7:0] seed, input int nbytes,
                          input logic [127:0] tuser, input logic [31:0] last_strb);
    int           nbeats;
    int           nwords;
    logic [191:0] pl;
    logic         lst;
    beat_t        b;
    nbeats = (nbytes + 31) / 32;
    nwords = nbeats + (nbeats + 2) / 3;
    feed_q.push_back(mkw({64'h0, tuser}, 5'd0, 3'd0, 1'b0));
    for (int i = 0; i < nwords; i++) begin
      for (int k = 0; k < 24; k++) pl[8*k +: 8] = seed + 8'(24*i + k);
      lst = (i == nwords - 1);
      feed_q.push_back(mkw(pl, lst ? 5'((nbytes - 1) % 32) : 5'd0, 3'((i % 4) + 1), lst));
    end
    for (int j = 0; j < nbeats; j++) begin
      for (int n = 0; n < 32; n++) b.data[8*n +: 8] = seed + 8'(32*j + n);
      b.strb = (j == nbeats - 1) ? last_strb : 32'hFFFF_FFFF;
      b.user = tuser;
      b.last = (j == nbeats - 1);
      b.cyc  = 0;
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_beats(input string tag, input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < 300) begin
      @(posedge clk); #1; k++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_beat_count"}, got_q.size(), n);
  endtask

  task automatic cmp_beats(input string tag);
    beat_t g;
    beat_t e;
    int    j;
    j = 0;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk($sformatf("%s_b%0d_data", tag, j), g.data, e.data);
      chk($sformatf("%s_b%0d_strb", tag, j), g.strb, e.strb);
      chk($sformatf("%s_b%0d_user", tag, j), g.user, e.user);
      chk($sformatf("%s_b%0d_last", tag, j), g.last, e.last);
      j++;
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic wait_tvalid(input string tag);
    int k;
    k = 0;
    while (!m_tvalid && k < 100) begin
      @(posedge clk); #1; k++;
    end
    chk({tag, "_tvalid_seen"}, m_tvalid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    logic [255:0] saved;
    reset    = 1'b1;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", m_tvalid, 1'b0);
    chk("rst_tlast", m_tlast, 1'b0);
    chk("rst_tdata", m_tdata, 256'h0);
    chk("rst_tstrb", m_tstrb, 32'h0);
    chk("rst_tuser", m_tuser, 128'h0);
    chk("rst_perr", proto_err, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: 96-byte packet, three beats on consecutive cycles
    send_pkt(8'h00, 96, {16{8'hA5}}, 32'hFFFF_FFFF);
    wait_beats("t1", 3);
    if (got_q.size() == 3) begin
      chk("t1_consec1", got_q[1].cyc - got_q[0].cyc, 1);
      chk("t1_consec2", got_q[2].cyc - got_q[1].cyc, 1);
    end
    cmp_beats("t1");

    // 2: 40-byte packet, second beat carries 8 valid bytes
    send_pkt(8'h40, 40, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 32'h0000_00FF);
    wait_beats("t2", 2);
    cmp_beats("t2");

    // 3: output stall mid-packet
    send_pkt(8'h80, 96, {16{8'h3C}}, 32'hFFFF_FFFF);
    wait_tvalid("t3");
    m_tready = 1'b0;
    saved    = m_tdata;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk($sformatf("t3_stall%0d_rd", s), din_rd, 1'b0);
      chk($sformatf("t3_stall%0d_data", s), m_tdata, saved);
    end
    @(posedge clk); #1;
    m_tready = 1'b1;
    wait_beats("t3", 3);
    cmp_beats("t3");

    // 4: back-to-back packets, each beat tagged with its own tuser
    send_pkt(8'h10, 96, {16{8'h11}}, 32'hFFFF_FFFF);
    send_pkt(8'h20, 40, {16{8'h22}}, 32'h0000_00FF);
    wait_beats("t4", 5);
    if (got_q.size() == 5) chk("t4_gap", got_q[3].cyc - got_q[2].cyc, 3);
    cmp_beats("t4");
    chk("t4_perr_none", perr_cnt, 0);

    // last=1 on the first data word is a protocol error
    p0 = perr_cnt;
    feed_q.push_back(mkw({64'h0, {16{8'h77}}}, 5'd0, 3'd0, 1'b0));
    feed_q.push_back(mkw({24{8'hEE}}, 5'd3, 3'd1, 1'b1));
    repeat (8) @(posedge clk);
    #1;
    chk("w1last_perr", perr_cnt - p0, 1);
    chk("w1last_nobeat", got_q.size(), 0);
    send_pkt(8'h60, 40, {16{8'h5A}}, 32'h0000_00FF);
    wait_beats("w1last", 2);
    cmp_beats("w1last");

    // 5: reset while a beat is pending in W3
    m_tready = 1'b0;
    send_pkt(8'h30, 96, {16{8'h99}}, 32'hFFFF_FFFF);
    wait_tvalid("t5");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("t5_rst_tvalid", m_tvalid, 1'b0);
    chk("t5_rst_tdata", m_tdata, 256'h0);
    chk("t5_rst_tuser", m_tuser, 128'h0);
    feed_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    got_q.delete();
    m_tready = 1'b1;
    send_pkt(8'h50, 40, {16{8'hC3}}, 32'h0000_00FF);
    wait_beats("t5", 2);
    cmp_beats("t5");

`ifdef FIFO2AXI_PHASE_CHECK_EN
    // 6: phase mismatch, resync on the next header
    p0 = perr_cnt;
    feed_q.push_back(mkw({64'h0, {16{8'hDD}}}, 5'd0, 3'd0, 1'b0));
    feed_q.push_back(mkw({24{8'h01}}, 5'd0, 3'd1, 1'b0));
    feed_q.push_back(mkw({24{8'h02}}, 5'd0, 3'd3, 1'b0));
    feed_q.push_back(mkw({24{8'h03}}, 5'd0, 3'd4, 1'b0));
    feed_q.push_back(mkw({24{8'h04}}, 5'd0, 3'd1, 1'b0));
    repeat (10) @(posedge clk);
    #1;
    chk("t6_perr_once", perr_cnt - p0, 1);
    chk("t6_nobeat", got_q.size(), 0);
    send_pkt(8'h70, 40, {16{8'hB4}}, 32'h0000_00FF);
    wait_beats("t6", 2);
    cmp_beats("t6");
    chk("t6_perr_total", perr_cnt - p0, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
